// File: rtl/fifo_cal_seq.sv
// Sequential stage behind the FIFO next-state decoder: state register, head/tail
// pointers, data_count and registered storage strobes. Optional error counter: FIFO_CAL_ERRCNT_EN.
module fifo_cal_seq #(
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        next_state,
  output logic [2:0]        state,
  output logic [CNT_W-1:0]  data_count,
  output logic              we,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              re,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              wr_ack,
  output logic              wr_err,
  output logic              rd_ack,
  output logic              rd_err,
  output logic              full,
  output logic              empty,
  output logic [7:0]        err_count
);

  typedef enum logic [2:0] {
    S_INIT     = 3'b000,
    S_READ     = 3'b001,
    S_WRITE    = 3'b010,
    S_RD_ERROR = 3'b011,
    S_WR_ERROR = 3'b100,
    S_NO_OP    = 3'b101
  } state_t;

  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(2 ** ADDR_W);

  state_t            state_q, state_n;
  logic [ADDR_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0]  count_q;
  logic              do_wr, do_rd;

  // we/re are single-cycle strobes with no ready/backpressure: storage must
  // accept each one on the cycle it is high; wr_addr/rd_addr are valid only then.
  always_comb begin
    state_n = S_NO_OP;
    do_wr   = 1'b0;
    do_rd   = 1'b0;
    case (next_state)
      3'b000: state_n = S_INIT;
      3'b001: begin
        if (count_q != '0) begin
          state_n = S_READ;
          do_rd   = 1'b1;
        end else begin
          state_n = S_RD_ERROR;
        end
      end
      3'b010: begin
        if (count_q != DEPTH) begin
          state_n = S_WRITE;
          do_wr   = 1'b1;
        end else begin
          state_n = S_WR_ERROR;
        end
      end
      3'b011:  state_n = S_RD_ERROR;
      3'b100:  state_n = S_WR_ERROR;
      3'b101:  state_n = S_NO_OP;
      default: state_n = S_NO_OP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INIT;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      we      <= 1'b0;
      re      <= 1'b0;
      wr_addr <= '0;
      rd_addr <= '0;
      wr_ack  <= 1'b0;
      rd_ack  <= 1'b0;
      wr_err  <= 1'b0;
      rd_err  <= 1'b0;
    end else begin
      state_q <= state_n;
      we      <= do_wr;
      re      <= do_rd;
      wr_ack  <= do_wr;
      rd_ack  <= do_rd;
      wr_addr <= tail_q;
      rd_addr <= head_q;
      wr_err  <= (state_n == S_WR_ERROR);
      rd_err  <= (state_n == S_RD_ERROR);
      if (do_wr) begin
        tail_q  <= tail_q + ADDR_W'(1);
        count_q <= count_q + CNT_W'(1);
      end else if (do_rd) begin
        head_q  <= head_q + ADDR_W'(1);
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

  assign state      = state_q;
  assign data_count = count_q;
  // Flags come from the count alone; equal pointers are ambiguous (empty or full).
  assign full       = (count_q == DEPTH);
  assign empty      = (count_q == '0);

`ifdef FIFO_CAL_ERRCNT_EN
  logic [7:0] err_cnt_q;
  logic       enter_err;

  assign enter_err = ((state_n == S_RD_ERROR) || (state_n == S_WR_ERROR)) && (state_n != state_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= 8'h00;
    end else if (enter_err && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'h01;
    end
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = 8'h00;
`endif

endmodule

// File: tb/tb_fifo_cal_seq.sv
// Table-driven bench for fifo_cal_seq plus hand-written reset and error-counter sequences.
module tb_fifo_cal_seq;

  localparam logic [2:0] INIT = 3'b000, READ = 3'b001, WRITE = 3'b010,
                         RDE = 3'b011, WRE = 3'b100, NOP = 3'b101;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] next_state;
  logic [2:0] state;
  logic [3:0] data_count;
  logic       we, re, wr_ack, wr_err, rd_ack, rd_err, full, empty;
  logic [2:0] wr_addr, rd_addr;
  logic [7:0] err_count;

  int total = 0;
  int bad   = 0;
  int exp_err = 0;
  logic [2:0] prev_exp_state = INIT;

  typedef struct {
    logic [2:0] ns;
    logic [2:0] st;
    logic       we;
    logic [2:0] wa;
    logic       re;
    logic [2:0] ra;
    logic       werr;
    logic       rerr;
    logic [3:0] cnt;
  } vec_t;

  vec_t tbl[$];

  fifo_cal_seq dut (
    .clk(clk), .rst(rst), .next_state(next_state), .state(state),
    .data_count(data_count), .we(we), .wr_addr(wr_addr), .re(re), .rd_addr(rd_addr),
    .wr_ack(wr_ack), .wr_err(wr_err), .rd_ack(rd_ack), .rd_err(rd_err),
    .full(full), .empty(empty), .err_count(err_count)
  );

  always #5 clk = ~clk;

  function automatic vec_t v(input logic [2:0] ns, input logic [2:0] st, input logic w,
                             input logic [2:0] wa, input logic r, input logic [2:0] ra,
                             input logic werr, input logic rerr, input logic [3:0] cnt);
    vec_t x;
    x.ns = ns; x.st = st; x.we = w; x.wa = wa; x.re = r; x.ra = ra;
    x.werr = werr; x.rerr = rerr; x.cnt = cnt;
    return x;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic [2:0] ns);
    next_state = ns;
    @(posedge clk);
    #1;
  endtask

  // Expected error count: +1 on entry to an error state from a different state, saturating.
  task automatic model_err(input logic [2:0] st);
`ifdef FIFO_CAL_ERRCNT_EN
    if ((st == RDE || st == WRE) && st != prev_exp_state && exp_err < 255) exp_err++;
`endif
    prev_exp_state = st;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    for (int i = 0; i < cycles; i++) step(next_state);
    rst = 1'b0;
    exp_err = 0;
    prev_exp_state = INIT;
  endtask

  task automatic check_vec(input string tag, input vec_t x);
    chk({tag, " state"}, state, x.st);
    chk({tag, " data_count"}, data_count, x.cnt);
    chk({tag, " we"}, we, x.we);
    chk({tag, " wr_ack"}, wr_ack, x.we);
    if (x.we) chk({tag, " wr_addr"}, wr_addr, x.wa);
    chk({tag, " re"}, re, x.re);
    chk({tag, " rd_ack"}, rd_ack, x.re);
    if (x.re) chk({tag, " rd_addr"}, rd_addr, x.ra);
    chk({tag, " wr_err"}, wr_err, x.werr);
    chk({tag, " rd_err"}, rd_err, x.rerr);
    chk({tag, " full"}, full, (x.cnt == 4'd8));
    chk({tag, " empty"}, empty, (x.cnt == 4'd0));
    chk({tag, " err_count"}, err_count, exp_err);
  endtask

  initial begin
    rst = 1'b1;
    next_state = INIT;

    // Full write burst, overflow, full read burst, underflow.
    for (int i = 0; i < 8; i++) tbl.push_back(v(WRITE, WRITE, 1, 3'(i), 0, 0, 0, 0, 4'(i + 1)));
    tbl.push_back(v(WRITE, WRE, 0, 0, 0, 0, 1, 0, 8));
    tbl.push_back(v(WRE,   WRE, 0, 0, 0, 0, 1, 0, 8));
    for (int i = 0; i < 8; i++) tbl.push_back(v(READ, READ, 0, 0, 1, 3'(i), 0, 0, 4'(7 - i)));
    tbl.push_back(v(READ, RDE, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(v(READ, RDE, 0, 0, 0, 0, 0, 1, 0));
    // Wrap: 5 in, 5 out, 5 in landing on 5,6,7,0,1.
    for (int i = 0; i < 5; i++) tbl.push_back(v(WRITE, WRITE, 1, 3'(i), 0, 0, 0, 0, 4'(i + 1)));
    for (int i = 0; i < 5; i++) tbl.push_back(v(READ, READ, 0, 0, 1, 3'(i), 0, 0, 4'(4 - i)));
    for (int i = 0; i < 5; i++) tbl.push_back(v(WRITE, WRITE, 1, 3'(5 + i), 0, 0, 0, 0, 4'(i + 1)));
    tbl.push_back(v(READ, READ, 0, 0, 1, 5, 0, 0, 4));
    tbl.push_back(v(READ, READ, 0, 0, 1, 6, 0, 0, 3));
    // Illegal codes, explicit error/idle states at count 3.
    tbl.push_back(v(3'b111, NOP, 0, 0, 0, 0, 0, 0, 3));
    tbl.push_back(v(3'b110, NOP, 0, 0, 0, 0, 0, 0, 3));
    tbl.push_back(v(RDE,  RDE,  0, 0, 0, 0, 0, 1, 3));
    tbl.push_back(v(WRE,  WRE,  0, 0, 0, 0, 1, 0, 3));
    tbl.push_back(v(INIT, INIT, 0, 0, 0, 0, 0, 0, 3));
    tbl.push_back(v(NOP,  NOP,  0, 0, 0, 0, 0, 0, 3));
    tbl.push_back(v(WRITE, WRITE, 1, 2, 0, 0, 0, 0, 4));
    tbl.push_back(v(READ,  READ,  0, 0, 1, 7, 0, 0, 3));

    // Reset held for two edges.
    do_reset(2);
    check_vec("reset", v(INIT, INIT, 0, 0, 0, 0, 0, 0, 0));

    foreach (tbl[i]) begin
      step(tbl[i].ns);
      model_err(tbl[i].st);
      check_vec($sformatf("vec%0d", i), tbl[i]);
    end

    // Reset in the middle of a write burst at count 4.
    do_reset(1);
    for (int i = 0; i < 4; i++) step(WRITE);
    chk("pre_rst data_count", data_count, 4);
    rst = 1'b1;
    step(WRITE);
    rst = 1'b0;
    exp_err = 0;
    prev_exp_state = INIT;
    check_vec("mid_rst", v(WRITE, INIT, 0, 0, 0, 0, 0, 0, 0));
    step(WRITE);
    model_err(WRITE);
    check_vec("post_rst write", v(WRITE, WRITE, 1, 0, 0, 0, 0, 0, 1));
    step(READ);
    model_err(READ);
    check_vec("post_rst read", v(READ, READ, 0, 0, 1, 0, 0, 0, 0));

    // Error held three cycles then a different error: counts two entries.
    do_reset(1);
    for (int i = 0; i < 3; i++) begin
      step(RDE);
      model_err(RDE);
      check_vec($sformatf("rde_hold%0d", i), v(RDE, RDE, 0, 0, 0, 0, 0, 1, 0));
    end
    step(WRE);
    model_err(WRE);
    check_vec("wre_after_rde", v(WRE, WRE, 0, 0, 0, 0, 1, 0, 0));
`ifdef FIFO_CAL_ERRCNT_EN
    chk("errcnt_two", err_count, 2);
`else
    chk("errcnt_tied", err_count, 0);
`endif
    step(NOP);
    model_err(NOP);
    check_vec("nop_after_err", v(NOP, NOP, 0, 0, 0, 0, 0, 0, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
